log_4decadas_a_porcentaje: RTL and testbench



---
 rtl/log_4decadas_a_porcentaje_if.sv | 13 +
 rtl/log_4decadas_a_porcentaje.sv | 133 +++++++++++++
 tb/tb_log_4decadas_a_porcentaje.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/log_4decadas_a_porcentaje_if.sv
// Start/done handshake bundle between a log-scale value source and the
// log-to-percentage converter.
interface log_4decadas_a_porcentaje_if;
    logic        start;
    logic [13:0] y;
    logic        busy;
    logic        done;
    logic [6:0]  x;
    logic        range_err;

    modport master (output start, output y, input busy, input done, input x, input range_err);
    modport slave  (input start, input y, output busy, output done, output x, output range_err);
endinterface

// File: rtl/log_4decadas_a_porcentaje.sv
// Log-scale magnitude (1..10000) back to a 0..100 percentage via a 7-step
// binary search over the 4-decade log table; fixed 8-clock latency.
//
// state     | meaning
// ST_IDLE   | waiting for start, busy low after the cycle following done
// ST_SEARCH | seven binary-search iterations on lo/hi
// ST_FIN    | publish x and range_err, pulse done
module log_4decadas_a_porcentaje (
    input  logic                            clk,
    input  logic                            reset,
    log_4decadas_a_porcentaje_if.slave      bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_FIN} state_t;

    state_t      state, state_n;
    logic [6:0]  lo, lo_n, hi, hi_n, mid;
    logic [13:0] y_q, y_n, f_mid;
    logic [2:0]  cnt, cnt_n;
    logic [6:0]  x_q, x_n;
    logic        err_q, err_n, done_q, done_n, busy_q, busy_n;

    // f(i) = round(10^(4*i/100)), half-up
    function automatic logic [13:0] lut(input logic [6:0] i);
        case (i)
            7'd0,  7'd1,  7'd2,  7'd3,  7'd4:          lut = 14'd1;
            7'd5,  7'd6,  7'd7,  7'd8,  7'd9:          lut = 14'd2;
            7'd10, 7'd11, 7'd12, 7'd13:                lut = 14'd3;
            7'd14, 7'd15, 7'd16:                       lut = 14'd4;
            7'd17, 7'd18:                              lut = 14'd5;
            7'd19, 7'd20:                              lut = 14'd6;
            7'd21: lut = 14'd7;     7'd22, 7'd23: lut = 14'd8;
            7'd24: lut = 14'd9;     7'd25: lut = 14'd10;    7'd26: lut = 14'd11;
            7'd27: lut = 14'd12;    7'd28: lut = 14'd13;    7'd29: lut = 14'd14;
            7'd30: lut = 14'd16;    7'd31: lut = 14'd17;    7'd32: lut = 14'd19;
            7'd33: lut = 14'd21;    7'd34: lut = 14'd23;    7'd35: lut = 14'd25;
            7'd36: lut = 14'd28;    7'd37: lut = 14'd30;    7'd38: lut = 14'd33;
            7'd39: lut = 14'd36;    7'd40: lut = 14'd40;    7'd41: lut = 14'd44;
            7'd42: lut = 14'd48;    7'd43: lut = 14'd52;    7'd44: lut = 14'd58;
            7'd45: lut = 14'd63;    7'd46: lut = 14'd69;    7'd47: lut = 14'd76;
            7'd48: lut = 14'd83;    7'd49: lut = 14'd91;    7'd50: lut = 14'd100;
            7'd51: lut = 14'd110;   7'd52: lut = 14'd120;   7'd53: lut = 14'd132;
            7'd54: lut = 14'd145;   7'd55: lut = 14'd158;   7'd56: lut = 14'd174;
            7'd57: lut = 14'd191;   7'd58: lut = 14'd209;   7'd59: lut = 14'd229;
            7'd60: lut = 14'd251;   7'd61: lut = 14'd275;   7'd62: lut = 14'd302;
            7'd63: lut = 14'd331;   7'd64: lut = 14'd363;   7'd65: lut = 14'd398;
            7'd66: lut = 14'd437;   7'd67: lut = 14'd479;   7'd68: lut = 14'd525;
            7'd69: lut = 14'd575;   7'd70: lut = 14'd631;   7'd71: lut = 14'd692;
            7'd72: lut = 14'd759;   7'd73: lut = 14'd832;   7'd74: lut = 14'd912;
            7'd75: lut = 14'd1000;  7'd76: lut = 14'd1096;  7'd77: lut = 14'd1202;
            7'd78: lut = 14'd1318;  7'd79: lut = 14'd1445;  7'd80: lut = 14'd1585;
            7'd81: lut = 14'd1738;  7'd82: lut = 14'd1905;  7'd83: lut = 14'd2089;
            7'd84: lut = 14'd2291;  7'd85: lut = 14'd2512;  7'd86: lut = 14'd2754;
            7'd87: lut = 14'd3020;  7'd88: lut = 14'd3311;  7'd89: lut = 14'd3631;
            7'd90: lut = 14'd3981;  7'd91: lut = 14'd4365;  7'd92: lut = 14'd4786;
            7'd93: lut = 14'd5248;  7'd94: lut = 14'd5754;  7'd95: lut = 14'd6310;
            7'd96: lut = 14'd6918;  7'd97: lut = 14'd7586;  7'd98: lut = 14'd8318;
            7'd99: lut = 14'd9120;
            default: lut = 14'd10000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            lo     <= '0;
            hi     <= '0;
            y_q    <= '0;
            cnt    <= '0;
            x_q    <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            lo     <= lo_n;
            hi     <= hi_n;
            y_q    <= y_n;
            cnt    <= cnt_n;
            x_q    <= x_n;
            err_q  <= err_n;
            done_q <= done_n;
            busy_q <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        lo_n    = lo;
        hi_n    = hi;
        y_n     = y_q;
        cnt_n   = cnt;
        x_n     = x_q;
        err_n   = err_q;
        done_n  = 1'b0;
        busy_n  = busy_q;
        mid     = 7'(({1'b0, lo} + {1'b0, hi}) >> 1);
        f_mid   = lut(mid);
        case (state)
            ST_IDLE: begin
                // busy stays up one cycle past FIN so it covers the done pulse
                busy_n = 1'b0;
                if (bus.start) begin
                    y_n     = bus.y;
                    lo_n    = 7'd0;
                    hi_n    = 7'd100;
                    cnt_n   = 3'd0;
                    busy_n  = 1'b1;
                    state_n = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (lo != hi) begin
                    if (f_mid >= y_q) hi_n = mid;
                    else              lo_n = mid + 7'd1;
                end
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd6) state_n = ST_FIN;
            end
            ST_FIN: begin
                x_n     = lo;
                err_n   = (y_q == 14'd0) || (y_q > 14'd10000);
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.x         = x_q;
    assign bus.range_err = err_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_log_4decadas_a_porcentaje.sv
// Bench for the log-to-percentage converter: fixed vectors, table sweep,
// random values against a real-arithmetic model, and handshake corner cases.
module tb_log_4decadas_a_porcentaje;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ftab [0:100];

    always #5 clk = ~clk;

    log_4decadas_a_porcentaje_if bus ();
    log_4decadas_a_porcentaje dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int y;
        int x;
        int err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_x(input int yv);
        for (int i = 0; i <= 100; i++)
            if (ftab[i] >= yv) return i;
        return 100;
    endfunction

    function automatic int ref_err(input int yv);
        return (yv == 0 || yv > 10000) ? 1 : 0;
    endfunction

    // one conversion; lat = edges from accepting edge to done, -1 on timeout
    task automatic convert(input int yv, output int xo, output int eo, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.y     = 14'(yv);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.y     = 14'($urandom);
        check("busy_after_start", int'(bus.busy), 1);
        lat = -1; xo = -1; eo = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                xo  = int'(bus.x);
                eo  = int'(bus.range_err);
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs [$];
        int xo, eo, lat, yv;
        int done_cnt, d1_edge, d1_x, d2_edge, d2_x;
        bit saw_done;

        for (int i = 0; i <= 100; i++) ftab[i] = $rtoi((10.0 ** (0.04 * i)) + 0.5);

        vecs = '{'{100, 50, 0}, '{101, 51, 0}, '{1000, 75, 0}, '{1, 0, 0},
                 '{10000, 100, 0}, '{12000, 100, 1}, '{0, 0, 1}, '{8, 22, 0},
                 '{5, 17, 0}, '{2, 5, 0}, '{9120, 99, 0}, '{9121, 100, 0},
                 '{16383, 100, 1}, '{1001, 76, 0}};

        bus.start = 1'b0;
        bus.y     = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", int'(bus.x), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_err", int'(bus.range_err), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            convert(vecs[i].y, xo, eo, lat);
            check($sformatf("vec_lat y=%0d", vecs[i].y), lat, 8);
            check($sformatf("vec_x y=%0d", vecs[i].y), xo, vecs[i].x);
            check($sformatf("vec_err y=%0d", vecs[i].y), eo, vecs[i].err);
        end

        for (int i = 0; i <= 100; i++) begin
            convert(ftab[i], xo, eo, lat);
            check($sformatf("sweep_x i=%0d", i), xo, ref_x(ftab[i]));
            check($sformatf("sweep_lat i=%0d", i), lat, 8);
            if (i < 100) begin
                convert(ftab[i] + 1, xo, eo, lat);
                check($sformatf("sweep_p1_x i=%0d", i), xo, ref_x(ftab[i] + 1));
            end
        end

        for (int r = 0; r < 150; r++) begin
            yv = (r % 5 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 10001));
            convert(yv, xo, eo, lat);
            check($sformatf("rand_x y=%0d", yv), xo, ref_x(yv));
            check($sformatf("rand_err y=%0d", yv), eo, ref_err(yv));
            check($sformatf("rand_lat y=%0d", yv), lat, 8);
        end

        // starts during search and during the done cycle must be dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.y     = 14'd100;
        @(posedge clk); #1;
        bus.y = 14'd5;
        done_cnt = 0; d1_edge = -1; d1_x = -1; d2_edge = -1; d2_x = -1;
        for (int e = 1; e <= 20; e++) begin
            bus.start = (e == 3 || e == 8 || e == 9);
            @(posedge clk); #1;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin d1_edge = e; d1_x = int'(bus.x); end
                if (done_cnt == 2) begin d2_edge = e; d2_x = int'(bus.x); end
            end
        end
        bus.start = 1'b0;
        check("ignore_done1_edge", d1_edge, 8);
        check("ignore_done1_x", d1_x, 50);
        check("ignore_done2_edge", d2_edge, 17);
        check("ignore_done2_x", d2_x, 17);
        check("ignore_done_count", done_cnt, 2);

        // reset in the middle of a conversion
        @(negedge clk);
        bus.start = 1'b1;
        bus.y     = 14'd100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_x", int'(bus.x), 0);
        check("midreset_busy", int'(bus.busy), 0);
        saw_done = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("midreset_no_done", int'(saw_done), 0);
        convert(2, xo, eo, lat);
        check("after_reset_x", xo, 5);
        check("after_reset_lat", lat, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
